// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - scheduler state encodings and mode constants shared with rsa_wrapper
package rsa_pkg;

    typedef enum logic [2:0] {
        SCH_IDLE  = 3'd0,
        SCH_CLEAR = 3'd1,
        SCH_START = 3'd2,
        SCH_BUSY  = 3'd3,
        SCH_RESP  = 3'd4
    } sch_state_t;

    localparam logic MODE_ENCRYPT = 1'b0;
    localparam logic MODE_DECRYPT = 1'b1;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rsa_exp_scheduler_if.sv
// rtl/rsa_exp_scheduler_if.sv - requester-side request/response bundle of the exponentiation scheduler
interface rsa_exp_scheduler_if #(
    parameter int DATA_W  = 1024,
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_mode;
    logic [NUM_REQ*DATA_W-1:0] req_msg;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [NUM_REQ-1:0]        rsp_ready;
    logic [DATA_W-1:0]         rsp_data;
    logic                      rsp_error;

    modport master (
        output req_valid, req_mode, req_msg, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_error
    );

    modport slave (
        input  req_valid, req_mode, req_msg, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_error
    );
endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin pick of the first request at or after ptr, wrapping
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    function automatic logic [IDX_W-1:0] wrap_idx(input int base, input int off);
        int s;
        s = base + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IDX_W'(s);
    endfunction

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!any && req[wrap_idx(int'(ptr), k)]) begin
                any                           = 1'b1;
                grant[wrap_idx(int'(ptr), k)] = 1'b1;
                idx                           = wrap_idx(int'(ptr), k);
            end
        end
    end

endmodule

// File: rtl/rsa_exp_scheduler.sv
// rtl/rsa_exp_scheduler.sv - shares one montgomery_exp core between requesters; RSA_SCHED_PERF_EN adds perf counters
module rsa_exp_scheduler
    import rsa_pkg::*;
#(
    parameter int DATA_W      = 1024,
    parameter int NUM_REQ     = 2,
    parameter int TIMEOUT_CYC = 2**24
) (
    input  logic                 clk,
    input  logic                 resetn,
    rsa_exp_scheduler_if.slave   host,
    input  logic [DATA_W-1:0]    key_e,
    input  logic [DATA_W-1:0]    key_d,
    input  logic [DATA_W-1:0]    key_n,
    input  logic [DATA_W-1:0]    key_rmodn,
    input  logic [DATA_W-1:0]    key_r2modn,
    output logic                 core_resetn,
    output logic                 core_start,
    output logic                 core_encrypt_mode,
    output logic [DATA_W-1:0]    core_msg,
    output logic [DATA_W-1:0]    core_exp,
    output logic [DATA_W-1:0]    core_n,
    output logic [DATA_W-1:0]    core_rmodn,
    output logic [DATA_W-1:0]    core_r2modn,
    input  logic [DATA_W-1:0]    core_result,
    input  logic                 core_done,
    output logic                 busy
`ifdef RSA_SCHED_PERF_EN
    ,
    output logic [31:0]          perf_cycles,
    output logic [15:0]          perf_jobs
`endif
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);

    sch_state_t          state, state_nx;
    logic [IDX_W-1:0]    rr_ptr;
    logic [IDX_W-1:0]    owner;
    logic [NUM_REQ-1:0]  gnt;
    logic [IDX_W-1:0]    gnt_idx;
    logic                gnt_any;
    logic                gnt_mode;
    logic [WD_W-1:0]     wd_cnt;
    logic                wd_expired;
    logic                job_end;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req   (host.req_valid),
        .ptr   (rr_ptr),
        .grant (gnt),
        .idx   (gnt_idx),
        .any   (gnt_any)
    );

    assign wd_expired = (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
    assign job_end    = (state == SCH_BUSY) && (core_done || wd_expired);
    assign gnt_mode   = host.req_mode[gnt_idx];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= SCH_IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            SCH_IDLE:  if (gnt_any) state_nx = SCH_CLEAR;
            SCH_CLEAR: state_nx = SCH_START;
            SCH_START: state_nx = SCH_BUSY;
            SCH_BUSY:  if (core_done || wd_expired) state_nx = SCH_RESP;
            SCH_RESP:  if (host.rsp_ready[owner]) state_nx = SCH_IDLE;
            default:   state_nx = SCH_IDLE;
        endcase
    end

    // Grant is combinational off req_valid, so it is masked while reset is held.
    always_comb begin
        host.req_ready = '0;
        host.rsp_valid = '0;
        core_start     = 1'b0;
        core_resetn    = 1'b0;
        busy           = (state != SCH_IDLE);
        case (state)
            SCH_IDLE:  host.req_ready = gnt & {NUM_REQ{resetn}};
            SCH_START: begin
                core_resetn = 1'b1;
                core_start  = 1'b1;
            end
            SCH_BUSY:  core_resetn = 1'b1;
            SCH_RESP: begin
                core_resetn           = 1'b1;
                host.rsp_valid[owner] = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_ptr            <= '0;
            owner             <= '0;
            core_msg          <= '0;
            core_exp          <= '0;
            core_encrypt_mode <= MODE_ENCRYPT;
            core_n            <= '0;
            core_rmodn        <= '0;
            core_r2modn       <= '0;
        end else if (state == SCH_IDLE && gnt_any) begin
            owner             <= gnt_idx;
            rr_ptr            <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
            core_msg          <= host.req_msg[int'(gnt_idx)*DATA_W +: DATA_W];
            core_encrypt_mode <= gnt_mode;
            core_exp          <= (gnt_mode == MODE_DECRYPT) ? key_d : key_e;
            core_n            <= key_n;
            core_rmodn        <= key_rmodn;
            core_r2modn       <= key_r2modn;
        end
    end

    // A done seen on the last watchdog cycle still counts as a good result.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wd_cnt         <= '0;
            host.rsp_data  <= '0;
            host.rsp_error <= 1'b0;
        end else if (state == SCH_START) begin
            wd_cnt <= '0;
        end else if (state == SCH_BUSY) begin
            wd_cnt <= wd_cnt + WD_W'(1);
            if (core_done) begin
                host.rsp_data  <= core_result;
                host.rsp_error <= 1'b0;
            end else if (wd_expired) begin
                host.rsp_data  <= '0;
                host.rsp_error <= 1'b1;
            end
        end
    end

`ifdef RSA_SCHED_PERF_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_cycles <= '0;
            perf_jobs   <= '0;
        end else if (job_end) begin
            perf_cycles <= 32'(wd_cnt) + 32'd1;
            perf_jobs   <= perf_jobs + 16'd1;
        end
    end
`else
    logic unused_job_end;
    assign unused_job_end = job_end;
`endif

endmodule

// File: tb/tb_rsa_exp_scheduler.sv
// tb/tb_rsa_exp_scheduler.sv - directed bench with a timeline model of the scheduler and a behavioural core
module tb_rsa_exp_scheduler;
    import rsa_pkg::*;

    localparam int DW = 32;
    localparam int NR = 2;
    localparam int TO = 64;

    typedef struct {
        logic [DW-1:0] msg;
        bit            mode;
    } job_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          resetn;
    logic [DW-1:0] key_e, key_d, key_n, key_rmodn, key_r2modn;
    logic          core_resetn, core_start, core_encrypt_mode, core_done, busy;
    logic [DW-1:0] core_msg, core_exp, core_n, core_rmodn, core_r2modn, core_result;
`ifdef RSA_SCHED_PERF_EN
    logic [31:0]   perf_cycles;
    logic [15:0]   perf_jobs;
`endif

    rsa_exp_scheduler_if #(.DATA_W(DW), .NUM_REQ(NR)) bus ();

    rsa_exp_scheduler #(.DATA_W(DW), .NUM_REQ(NR), .TIMEOUT_CYC(TO)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .host              (bus),
        .key_e             (key_e),
        .key_d             (key_d),
        .key_n             (key_n),
        .key_rmodn         (key_rmodn),
        .key_r2modn        (key_r2modn),
        .core_resetn       (core_resetn),
        .core_start        (core_start),
        .core_encrypt_mode (core_encrypt_mode),
        .core_msg          (core_msg),
        .core_exp          (core_exp),
        .core_n            (core_n),
        .core_rmodn        (core_rmodn),
        .core_r2modn       (core_r2modn),
        .core_result       (core_result),
        .core_done         (core_done),
        .busy              (busy)
`ifdef RSA_SCHED_PERF_EN
        ,
        .perf_cycles       (perf_cycles),
        .perf_jobs         (perf_jobs)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Core stand-in: done rises core_lat cycles after the start cycle, result = msg + exp.
    int core_lat  = 10;
    bit core_hang = 1'b0;
    int ccnt;
    bit crun;

    always @(posedge clk) begin
        if (!core_resetn) begin
            core_done   <= 1'b0;
            core_result <= '0;
            crun        <= 1'b0;
            ccnt        <= 0;
        end else if (core_start) begin
            crun <= 1'b1;
            ccnt <= 1;
        end else if (crun && !core_hang) begin
            if (ccnt == core_lat - 1) begin
                core_done   <= 1'b1;
                core_result <= core_msg + core_exp;
                crun        <= 1'b0;
            end else begin
                ccnt <= ccnt + 1;
            end
        end
    end

    // Timeline model: a job accepted at cycle t starts at t+2 and answers at start+1+latency.
    bit            m_job = 1'b0;
    int            m_start, m_rsp, m_owner;
    int            m_ptr = 0;
    logic [DW-1:0] m_msg, m_exp, m_data;
    bit            m_mode, m_err;

    logic [1:0]    acc_seen = '0;
    int            gq[$];
    logic [DW-1:0] rdata_q[$];
    int            rown_q[$];
    bit            rerr_q[$];
    int            acc_cyc, st_cyc, rsp_cyc;
    int            st_cnt = 0;
    logic [DW-1:0] st_exp;
    bit            st_mode;
    bit            rv_prev = 1'b0;

    always @(negedge clk) begin : model
        logic [1:0] e_ready, e_rv;
        bit         e_start, pre;
        int         w;
        cyc++;
        if (!resetn) begin
            chk("rst_req_ready",   bus.req_ready,     0);
            chk("rst_rsp_valid",   bus.rsp_valid,     0);
            chk("rst_rsp_error",   bus.rsp_error,     0);
            chk("rst_rsp_data",    bus.rsp_data,      0);
            chk("rst_core_start",  core_start,        0);
            chk("rst_core_resetn", core_resetn,       0);
            chk("rst_busy",        busy,              0);
            chk("rst_core_msg",    core_msg,          0);
            chk("rst_core_exp",    core_exp,          0);
            chk("rst_core_n",      core_n,            0);
            chk("rst_core_mode",   core_encrypt_mode, 0);
            m_job    = 1'b0;
            m_ptr    = 0;
            acc_seen = '0;
            rv_prev  = 1'b0;
        end else begin
            pre     = m_job;
            e_ready = '0;
            e_rv    = '0;
            e_start = 1'b0;
            if (!pre) begin
                if (bus.req_valid != 0) begin
                    w          = bus.req_valid[m_ptr] ? m_ptr : 1 - m_ptr;
                    e_ready[w] = 1'b1;
                    m_job      = 1'b1;
                    m_start    = cyc + 2;
                    m_owner    = w;
                    m_mode     = bus.req_mode[w];
                    m_msg      = bus.req_msg[w*DW +: DW];
                    m_exp      = m_mode ? key_d : key_e;
                    m_err      = core_hang;
                    m_data     = core_hang ? '0 : m_msg + m_exp;
                    m_rsp      = m_start + 1 + (core_hang ? TO : core_lat);
                    m_ptr      = 1 - w;
                end
            end else begin
                e_start = (cyc == m_start);
                if (cyc >= m_rsp) e_rv[m_owner] = 1'b1;
                chk("core_msg",    core_msg,          m_msg);
                chk("core_exp",    core_exp,          m_exp);
                chk("core_mode",   core_encrypt_mode, m_mode);
                chk("core_n",      core_n,            key_n);
                chk("core_rmodn",  core_rmodn,        key_rmodn);
                chk("core_r2modn", core_r2modn,       key_r2modn);
            end
            chk("req_ready",   bus.req_ready, e_ready);
            chk("rsp_valid",   bus.rsp_valid, e_rv);
            chk("core_start",  core_start,    e_start);
            chk("core_resetn", core_resetn,   pre && (cyc >= m_start));
            chk("busy",        busy,          pre);
            if (e_rv != 0) begin
                chk("rsp_data",  bus.rsp_data,  m_data);
                chk("rsp_error", bus.rsp_error, m_err);
                if (bus.rsp_ready[m_owner]) m_job = 1'b0;
            end

            if (bus.req_ready != 0) begin
                gq.push_back(bus.req_ready[1] ? 1 : 0);
                acc_cyc = cyc;
            end
            if (core_start) begin
                st_cyc  = cyc;
                st_exp  = core_exp;
                st_mode = core_encrypt_mode;
                st_cnt++;
            end
            if (bus.rsp_valid != 0 && !rv_prev) begin
                rdata_q.push_back(bus.rsp_data);
                rerr_q.push_back(bus.rsp_error);
                rown_q.push_back(bus.rsp_valid == 2'b01 ? 0 : (bus.rsp_valid == 2'b10 ? 1 : 9));
                rsp_cyc = cyc;
            end
            rv_prev  = (bus.rsp_valid != 0);
            acc_seen = bus.req_valid & bus.req_ready;
        end
    end

    job_t q0[$], q1[$];

    task automatic step();
        job_t j;
        @(posedge clk);
        #1;
        if (acc_seen[0]) bus.req_valid[0] = 1'b0;
        if (acc_seen[1]) bus.req_valid[1] = 1'b0;
        if (!bus.req_valid[0] && q0.size() > 0) begin
            j = q0.pop_front();
            bus.req_valid[0]      = 1'b1;
            bus.req_msg[0 +: DW]  = j.msg;
            bus.req_mode[0]       = j.mode;
        end
        if (!bus.req_valid[1] && q1.size() > 0) begin
            j = q1.pop_front();
            bus.req_valid[1]      = 1'b1;
            bus.req_msg[DW +: DW] = j.msg;
            bus.req_mode[1]       = j.mode;
        end
    endtask

    task automatic wait_quiet(input string name, input int bound);
        int n = 0;
        while ((busy || bus.req_valid != 0 || q0.size() != 0 || q1.size() != 0) && n < bound) begin
            step();
            n++;
        end
        chk({name, "_quiet_in_time"}, n < bound, 1);
    endtask

    task automatic wait_rsp(input string name, input int who, input int bound);
        int n = 0;
        while (!bus.rsp_valid[who] && n < bound) begin
            step();
            n++;
        end
        chk({name, "_rsp_in_time"}, n < bound, 1);
    endtask

    task automatic clear_logs();
        gq.delete();
        rdata_q.delete();
        rown_q.delete();
        rerr_q.delete();
    endtask

    initial begin
        int g0, r0, s0, n;
        resetn         = 1'b0;
        bus.req_valid  = '0;
        bus.req_mode   = '0;
        bus.req_msg    = '0;
        bus.rsp_ready  = 2'b11;
        key_e          = 32'h0000_122F;
        key_d          = 32'h0000_4000;
        key_n          = 32'hC0FF_EE01;
        key_rmodn      = 32'h0000_0011;
        key_r2modn     = 32'h0000_0022;
        repeat (3) step();
        resetn = 1'b1;

        // both requesters twice with rr_ptr=0: grants alternate 0,1,0,1
        clear_logs();
        q0.push_back('{32'h11, MODE_ENCRYPT});
        q1.push_back('{32'h22, MODE_ENCRYPT});
        q0.push_back('{32'h33, MODE_ENCRYPT});
        q1.push_back('{32'h44, MODE_ENCRYPT});
        wait_quiet("t2", 400);
        chk("t2_grant_count", gq.size(), 4);
        if (gq.size() == 4) begin
            chk("t2_grant0", gq[0], 0);
            chk("t2_grant1", gq[1], 1);
            chk("t2_grant2", gq[2], 0);
            chk("t2_grant3", gq[3], 1);
        end
        chk("t2_rsp_count", rdata_q.size(), 4);
        if (rdata_q.size() == 4) begin
            chk("t2_data0", rdata_q[0], 32'h1240);
            chk("t2_data1", rdata_q[1], 32'h1251);
            chk("t2_data2", rdata_q[2], 32'h1262);
            chk("t2_data3", rdata_q[3], 32'h1273);
            chk("t2_owner1", rown_q[1], 1);
        end

        // single encrypt job from requester 0
        clear_logs();
        q0.push_back('{32'h5, MODE_ENCRYPT});
        wait_quiet("t1", 100);
        chk("t1_rsp_count", rdata_q.size(), 1);
        if (rdata_q.size() == 1) begin
            chk("t1_data",  rdata_q[0], 32'h1234);
            chk("t1_owner", rown_q[0],  0);
            chk("t1_error", rerr_q[0],  0);
        end
        chk("t1_accept_to_start", st_cyc - acc_cyc, 2);
        chk("t1_start_to_rsp",    rsp_cyc - st_cyc, 11);
        chk("t1_exp",             st_exp,  32'h122F);
        chk("t1_mode",            st_mode, 0);

        // decrypt from requester 1, response held off while requester 0 waits
        clear_logs();
        bus.rsp_ready = 2'b01;
        q1.push_back('{32'h77, MODE_DECRYPT});
        wait_rsp("t3", 1, 100);
        q0.push_back('{32'h9, MODE_ENCRYPT});
        g0 = gq.size();
        repeat (5) step();
        chk("t3_rsp_valid_held", bus.rsp_valid, 2'b10);
        chk("t3_rsp_data_held",  bus.rsp_data,  32'h4077);
        chk("t3_no_new_grant",   gq.size(),     g0);
        chk("t3_exp",            st_exp,        32'h4000);
        chk("t3_mode",           st_mode,       1);
        bus.rsp_ready = 2'b11;
        wait_quiet("t3", 100);
        chk("t3_rsp_count", rdata_q.size(), 2);
        if (rdata_q.size() == 2) begin
            chk("t3_data2",  rdata_q[1], 32'h1238);
            chk("t3_owner2", rown_q[1],  0);
        end

        // hung core: watchdog fires after 64 busy cycles
        clear_logs();
        core_hang = 1'b1;
        q0.push_back('{32'h55, MODE_ENCRYPT});
        wait_quiet("t4", 300);
        core_hang = 1'b0;
        chk("t4_rsp_count", rdata_q.size(), 1);
        if (rdata_q.size() == 1) begin
            chk("t4_error", rerr_q[0],  1);
            chk("t4_data",  rdata_q[0], 0);
        end
        chk("t4_busy_cycles", rsp_cyc - st_cyc - 1, 64);

        // reset in the middle of a job: no response afterwards
        clear_logs();
        s0 = st_cnt;
        n  = 0;
        q0.push_back('{32'h66, MODE_ENCRYPT});
        while (st_cnt == s0 && n < 50) begin
            step();
            n++;
        end
        chk("t5_start_in_time", n < 50, 1);
        repeat (3) step();
        r0     = rdata_q.size();
        resetn = 1'b0;
        step();
        step();
        resetn = 1'b1;
        repeat (20) step();
        chk("t5_no_rsp",  rdata_q.size(), r0);
        chk("t5_idle",    busy,           0);

`ifdef RSA_SCHED_PERF_EN
        chk("t6_jobs_after_reset", perf_jobs, 0);
        q0.push_back('{32'h1, MODE_ENCRYPT});
        q0.push_back('{32'h2, MODE_ENCRYPT});
        wait_quiet("t6", 200);
        chk("t6_perf_cycles", perf_cycles, 10);
        chk("t6_perf_jobs",   perf_jobs,   2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
